// File: rtl/cpu_phase_gen_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_phase_gen_if : control/status bundle of the CPU/ANTIC timebase |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface cpu_phase_gen_if;
  logic       run;
  logic       halt_req;
  logic       phi1_en;
  logic       phi2_en;
  logic       phi2;
  logic       cpu_rdy;
  logic [6:0] cycle_cnt;
  logic [8:0] line_cnt;
  logic       line_start;
  logic       frame_start;
  logic [7:0] stolen_cnt;

  // master = the timebase generator, slave = its consumer/controller
  modport master (
    input  run, halt_req,
    output phi1_en, phi2_en, phi2, cpu_rdy, cycle_cnt, line_cnt,
           line_start, frame_start, stolen_cnt
  );

  modport slave (
    output run, halt_req,
    input  phi1_en, phi2_en, phi2, cpu_rdy, cycle_cnt, line_cnt,
           line_start, frame_start, stolen_cnt
  );
endinterface
`default_nettype wire

// File: rtl/cpu_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_phase_gen : phi1/phi2 enables, RDY cycle stealing, beam counts |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module cpu_phase_gen #(
  parameter int ACC_W        = 16,
  parameter int INC          = 1,
  parameter int MOD          = 8,
  parameter int CYC_PER_LINE = 114,
  parameter int LINES        = 262
) (
  input  logic            clkin,
  input  logic            RST,
  cpu_phase_gen_if.master pg
);

  localparam logic [ACC_W:0] C_INC       = (ACC_W+1)'(INC);
  localparam logic [ACC_W:0] C_MOD       = (ACC_W+1)'(MOD);
  localparam logic [6:0]     C_CYC_LAST  = 7'(CYC_PER_LINE - 1);
  localparam logic [8:0]     C_LINE_LAST = 9'(LINES - 1);

  typedef enum logic {
    PH1 = 1'b0,
    PH2 = 1'b1
  } phase_t;

  phase_t           phase_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W:0]   acc_sum;
  logic             tick;
  logic             phi1_en_q;
  logic             phi2_en_q;
  logic             phi2_q;
  logic             cpu_rdy_q;
  logic [6:0]       cycle_q;
  logic [8:0]       line_q;
  logic             line_start_q;
  logic             frame_start_q;
  logic [7:0]       stolen_q;
  logic             cyc_wrap;
  logic             line_wrap;

  // One extra sum bit keeps acc+INC exact before the modulus compare.
  always_comb begin
    acc_sum = {1'b0, acc_q} + C_INC;
    tick    = 1'b0;
    acc_d   = acc_q;
    if (pg.run) begin
      if (acc_sum >= C_MOD) begin
        tick  = 1'b1;
        acc_d = ACC_W'(acc_sum - C_MOD);
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  assign cyc_wrap  = (cycle_q == C_CYC_LAST);
  assign line_wrap = (line_q == C_LINE_LAST);

  always_ff @(posedge clkin or posedge RST) begin
    if (RST) begin
      acc_q         <= '0;
      phase_q       <= PH2;
      phi1_en_q     <= 1'b0;
      phi2_en_q     <= 1'b0;
      phi2_q        <= 1'b1;
      cpu_rdy_q     <= 1'b1;
      cycle_q       <= C_CYC_LAST;
      line_q        <= C_LINE_LAST;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      stolen_q      <= 8'd0;
    end else begin
      acc_q         <= acc_d;
      phi1_en_q     <= 1'b0;
      phi2_en_q     <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (tick) begin
        case (phase_q)
          PH2: begin
            phase_q   <= PH1;
            phi1_en_q <= 1'b1;
            phi2_q    <= 1'b0;
            cpu_rdy_q <= ~pg.halt_req;
            if (cyc_wrap) begin
              cycle_q      <= 7'd0;
              line_start_q <= 1'b1;
              stolen_q     <= {7'd0, pg.halt_req};
              if (line_wrap) begin
                line_q        <= 9'd0;
                frame_start_q <= 1'b1;
              end else begin
                line_q <= line_q + 9'd1;
              end
            end else begin
              cycle_q <= cycle_q + 7'd1;
              if (pg.halt_req && (stolen_q != 8'hFF)) begin
                stolen_q <= stolen_q + 8'd1;
              end
            end
          end
          default: begin
            phase_q   <= PH2;
            phi2_en_q <= 1'b1;
            phi2_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  assign pg.phi1_en     = phi1_en_q;
  assign pg.phi2_en     = phi2_en_q;
  assign pg.phi2        = phi2_q;
  assign pg.cpu_rdy     = cpu_rdy_q;
  assign pg.cycle_cnt   = cycle_q;
  assign pg.line_cnt    = line_q;
  assign pg.line_start  = line_start_q;
  assign pg.frame_start = frame_start_q;
  assign pg.stolen_cnt  = stolen_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cpu_phase_gen : directed bench over four parameter sets         |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_cpu_phase_gen;

  logic clkin = 1'b0;
  logic rst0  = 1'b1;
  logic rst1  = 1'b1;
  logic rst2  = 1'b1;
  logic rst3  = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clkin = ~clkin;

  cpu_phase_gen_if if0 ();
  cpu_phase_gen_if if1 ();
  cpu_phase_gen_if if2 ();
  cpu_phase_gen_if if3 ();

  cpu_phase_gen #(.ACC_W(16), .INC(1), .MOD(8), .CYC_PER_LINE(114), .LINES(262))
    dut0 (.clkin(clkin), .RST(rst0), .pg(if0));
  cpu_phase_gen #(.ACC_W(16), .INC(3), .MOD(8), .CYC_PER_LINE(114), .LINES(262))
    dut1 (.clkin(clkin), .RST(rst1), .pg(if1));
  cpu_phase_gen #(.ACC_W(16), .INC(8), .MOD(8), .CYC_PER_LINE(4), .LINES(3))
    dut2 (.clkin(clkin), .RST(rst2), .pg(if2));
  cpu_phase_gen #(.ACC_W(16), .INC(8), .MOD(8), .CYC_PER_LINE(127), .LINES(1))
    dut3 (.clkin(clkin), .RST(rst3), .pg(if3));

  task automatic step(input int n);
    repeat (n) @(posedge clkin);
    #1;
  endtask

  task automatic wait_phi1(input int which, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      step(1);
      case (which)
        2:       ok = if2.phi1_en;
        default: ok = if0.phi1_en;
      endcase
    end
  endtask

  task automatic test_reset();
    step(2);
    n_checks++;
    if ({if0.phi1_en, if0.phi2_en, if0.phi2, if0.cpu_rdy, if0.line_start, if0.frame_start} !== 6'b001100)
      $display("FAIL reset_flags: got %b want 001100",
               {if0.phi1_en, if0.phi2_en, if0.phi2, if0.cpu_rdy, if0.line_start, if0.frame_start});
    else n_pass++;
    n_checks++;
    if (if0.cycle_cnt !== 7'd113) $display("FAIL reset_cycle: got %0d want 113", if0.cycle_cnt);
    else n_pass++;
    n_checks++;
    if (if0.line_cnt !== 9'd261) $display("FAIL reset_line: got %0d want 261", if0.line_cnt);
    else n_pass++;
    n_checks++;
    if (if0.stolen_cnt !== 8'd0) $display("FAIL reset_stolen: got %0d want 0", if0.stolen_cnt);
    else n_pass++;
  endtask

  task automatic test_latency();
    logic [2:0] exp_v;
    if0.run = 1'b1;
    rst0    = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step(1);
      exp_v = {(e == 8 || e == 24), (e == 16), (e < 8 || (e >= 16 && e < 24))};
      n_checks++;
      if ({if0.phi1_en, if0.phi2_en, if0.phi2} !== exp_v)
        $display("FAIL latency_edge%0d: got %b want %b", e, {if0.phi1_en, if0.phi2_en, if0.phi2}, exp_v);
      else n_pass++;
      if (e == 8) begin
        n_checks++;
        if ({if0.cycle_cnt, if0.line_cnt, if0.line_start, if0.frame_start} !== {7'd0, 9'd0, 2'b11})
          $display("FAIL first_phi1: cycle %0d line %0d ls %b fs %b want 0 0 1 1",
                   if0.cycle_cnt, if0.line_cnt, if0.line_start, if0.frame_start);
        else n_pass++;
      end
    end
  endtask

  task automatic test_line_wrap();
    bit ok;
    int missing = 0;
    for (int i = 0; i < 112; i++) begin
      wait_phi1(0, 20, ok);
      if (!ok) missing++;
    end
    n_checks++;
    if (missing != 0 || if0.cycle_cnt !== 7'd113 || if0.line_cnt !== 9'd0)
      $display("FAIL line_end: cycle %0d line %0d timeouts %0d want 113 0 0", if0.cycle_cnt, if0.line_cnt, missing);
    else n_pass++;
    wait_phi1(0, 20, ok);
    n_checks++;
    if (!ok || {if0.cycle_cnt, if0.line_cnt, if0.line_start, if0.frame_start} !== {7'd0, 9'd1, 2'b10})
      $display("FAIL line_wrap: cycle %0d line %0d ls %b fs %b want 0 1 1 0",
               if0.cycle_cnt, if0.line_cnt, if0.line_start, if0.frame_start);
    else n_pass++;
  endtask

  task automatic test_halt();
    bit ok;
    int low = 0;
    if0.halt_req = 1'b1;
    wait_phi1(0, 20, ok);
    if0.halt_req = 1'b0;
    n_checks++;
    if (!ok || if0.cpu_rdy !== 1'b0 || if0.stolen_cnt !== 8'd1)
      $display("FAIL halt_take: rdy %b stolen %0d want 0 1", if0.cpu_rdy, if0.stolen_cnt);
    else n_pass++;
    for (int k = 1; k <= 15; k++) begin
      step(1);
      if (if0.cpu_rdy === 1'b0) low++;
    end
    step(1);
    n_checks++;
    if (low != 15 || if0.cpu_rdy !== 1'b1 || if0.phi1_en !== 1'b1)
      $display("FAIL halt_width: low %0d+1 clkin, rdy after %b want 15+1 and 1", low, if0.cpu_rdy);
    else n_pass++;
    step(5);
    if0.halt_req = 1'b1;
    step(3);
    if0.halt_req = 1'b0;
    wait_phi1(0, 20, ok);
    n_checks++;
    if (!ok || if0.cpu_rdy !== 1'b1 || if0.stolen_cnt !== 8'd1)
      $display("FAIL halt_between: rdy %b stolen %0d want 1 1", if0.cpu_rdy, if0.stolen_cnt);
    else n_pass++;
  endtask

  task automatic test_stolen_line();
    bit ok;
    bit found = 1'b0;
    for (int i = 0; i < 130 && !found; i++) begin
      wait_phi1(0, 20, ok);
      found = ok && (if0.cycle_cnt == 7'd113);
    end
    n_checks++;
    if (!found) $display("FAIL find_cycle113: got %0d want 113", if0.cycle_cnt);
    else n_pass++;
    if0.halt_req = 1'b1;
    wait_phi1(0, 20, ok);
    n_checks++;
    if (!ok || if0.line_start !== 1'b1 || if0.stolen_cnt !== 8'd1 || if0.cpu_rdy !== 1'b0)
      $display("FAIL stolen_linestart: ls %b stolen %0d rdy %b want 1 1 0", if0.line_start, if0.stolen_cnt, if0.cpu_rdy);
    else n_pass++;
    for (int i = 0; i < 113; i++) wait_phi1(0, 20, ok);
    n_checks++;
    if (if0.cycle_cnt !== 7'd113 || if0.stolen_cnt !== 8'd114)
      $display("FAIL stolen_full_line: cycle %0d stolen %0d want 113 114", if0.cycle_cnt, if0.stolen_cnt);
    else n_pass++;
    wait_phi1(0, 20, ok);
    n_checks++;
    if (!ok || if0.line_start !== 1'b1 || if0.stolen_cnt !== 8'd1)
      $display("FAIL stolen_reload: ls %b stolen %0d want 1 1", if0.line_start, if0.stolen_cnt);
    else n_pass++;
    if0.halt_req = 1'b0;
  endtask

  task automatic test_freeze_reset();
    int bad = 0;
    rst0 = 1'b1;
    step(1);
    rst0 = 1'b0;
    step(8);
    n_checks++;
    if (if0.phi1_en !== 1'b1 || if0.cycle_cnt !== 7'd0)
      $display("FAIL freeze_setup: phi1_en %b cycle %0d want 1 0", if0.phi1_en, if0.cycle_cnt);
    else n_pass++;
    step(3);
    if0.run      = 1'b0;
    if0.halt_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if ({if0.phi1_en, if0.phi2_en, if0.phi2, if0.cpu_rdy} !== 4'b0001 ||
          if0.cycle_cnt !== 7'd0 || if0.line_cnt !== 9'd0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL frozen_hold: %0d bad edges want 0", bad);
    else n_pass++;
    if0.halt_req = 1'b0;
    if0.run      = 1'b1;
    step(4);
    n_checks++;
    if (if0.phi2_en !== 1'b0) $display("FAIL resume_early: phi2_en %b want 0", if0.phi2_en);
    else n_pass++;
    step(1);
    n_checks++;
    if (if0.phi2_en !== 1'b1 || if0.phi2 !== 1'b1)
      $display("FAIL resume_tick: phi2_en %b phi2 %b want 1 1", if0.phi2_en, if0.phi2);
    else n_pass++;
    step(8);
    n_checks++;
    if (if0.phi1_en !== 1'b1 || if0.cycle_cnt !== 7'd1)
      $display("FAIL resume_phi1: phi1_en %b cycle %0d want 1 1", if0.phi1_en, if0.cycle_cnt);
    else n_pass++;
    step(2);
    #3 rst0 = 1'b1;
    #1;
    n_checks++;
    if ({if0.phi2, if0.cpu_rdy, if0.line_start, if0.phi1_en} !== 4'b1100 ||
        if0.cycle_cnt !== 7'd113 || if0.line_cnt !== 9'd261 || if0.stolen_cnt !== 8'd0)
      $display("FAIL async_reset: phi2 %b cycle %0d line %0d stolen %0d want 1 113 261 0",
               if0.phi2, if0.cycle_cnt, if0.line_cnt, if0.stolen_cnt);
    else n_pass++;
    step(2);
    rst0 = 1'b0;
    bad  = 0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      if (if0.phi1_en !== (e == 8) || if0.phi2_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || if0.frame_start !== 1'b1)
      $display("FAIL post_reset_latency: bad edges %0d fs %b want 0 1", bad, if0.frame_start);
    else n_pass++;
  endtask

  task automatic test_frac();
    int bad = 0;
    int n1  = 0;
    int n2  = 0;
    bit exp_t;
    if1.run = 1'b1;
    rst1    = 1'b0;
    for (int e = 1; e <= 64; e++) begin
      step(1);
      exp_t = (e % 8 == 3) || (e % 8 == 6) || (e % 8 == 0);
      if ((if1.phi1_en | if1.phi2_en) !== exp_t) bad++;
      if (if1.phi1_en === 1'b1) n1++;
      if (if1.phi2_en === 1'b1) n2++;
      if (e == 3) begin
        n_checks++;
        if (if1.phi1_en !== 1'b1) $display("FAIL frac_first: phi1_en %b at edge 3 want 1", if1.phi1_en);
        else n_pass++;
      end
      if (e == 64) begin
        n_checks++;
        if (if1.phi2_en !== 1'b1) $display("FAIL frac_edge64: phi2_en %b want 1", if1.phi2_en);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL frac_spacing: %0d edges off the 3/3/2 pattern want 0", bad);
    else n_pass++;
    n_checks++;
    if (n1 != 12 || n2 != 12) $display("FAIL frac_counts: phi1 %0d phi2 %0d want 12 12", n1, n2);
    else n_pass++;
  endtask

  task automatic test_frame();
    bit ok;
    int missing = 0;
    if2.run = 1'b1;
    rst2    = 1'b0;
    wait_phi1(2, 4, ok);
    n_checks++;
    if (!ok || {if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start} !== {7'd0, 9'd0, 2'b11})
      $display("FAIL frame_first: cycle %0d line %0d ls %b fs %b want 0 0 1 1",
               if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      wait_phi1(2, 4, ok);
      if (!ok) missing++;
    end
    n_checks++;
    if (missing != 0 || {if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start} !== {7'd0, 9'd1, 2'b10})
      $display("FAIL frame_line1: cycle %0d line %0d ls %b fs %b want 0 1 1 0",
               if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      wait_phi1(2, 4, ok);
      if (!ok) missing++;
    end
    n_checks++;
    if (missing != 0 || {if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start} !== {7'd0, 9'd0, 2'b11})
      $display("FAIL frame_wrap: cycle %0d line %0d ls %b fs %b want 0 0 1 1",
               if2.cycle_cnt, if2.line_cnt, if2.line_start, if2.frame_start);
    else n_pass++;
  endtask

  task automatic test_back_to_back_halt();
    int max_st = 0;
    int bad    = 0;
    if3.halt_req = 1'b1;
    if3.run      = 1'b1;
    rst3         = 1'b0;
    for (int e = 0; e < 600; e++) begin
      step(1);
      if (int'(if3.stolen_cnt) > max_st) max_st = int'(if3.stolen_cnt);
      if (if3.frame_start !== if3.line_start || if3.line_cnt !== 9'd0) bad++;
    end
    n_checks++;
    if (max_st != 127) $display("FAIL stolen_max: got %0d want 127", max_st);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL single_line_frame: %0d bad edges want 0", bad);
    else n_pass++;
  endtask

  initial begin
    if0.run = 1'b0; if0.halt_req = 1'b0;
    if1.run = 1'b0; if1.halt_req = 1'b0;
    if2.run = 1'b0; if2.halt_req = 1'b0;
    if3.run = 1'b0; if3.halt_req = 1'b0;
    test_reset();
    test_latency();
    test_line_wrap();
    test_halt();
    test_stolen_line();
    test_freeze_reset();
    test_frac();
    test_frame();
    test_back_to_back_halt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
